// File: rtl/mobilenet_v1_pw_group_sched.sv
// Pointwise weight-group scheduler: walks every output-channel group of a layer,
// fetching each group from the param cache and handing it to the PW engine.
module mobilenet_v1_pw_group_sched #(
    parameter int unsigned DIM_W       = 16,
    parameter int unsigned PW_OC_PAR   = 32,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 layer_start,
    input  logic [DIM_W-1:0]     layer_out_c,
    input  logic                 abort,
    output logic                 layer_busy,
    output logic                 layer_done,
    output logic                 layer_err,
    output logic                 timeout_err,
    output logic                 pw_group_req,
    output logic [DIM_W-1:0]     pw_group_idx,
    input  logic                 pw_group_ready,
    output logic                 grp_valid,
    output logic [DIM_W-1:0]     grp_idx,
    output logic [PW_OC_PAR-1:0] grp_lane_mask,
    input  logic                 grp_done
);

    localparam int unsigned NW       = DIM_W + 1;
    localparam int unsigned LOG2_PAR = $clog2(PW_OC_PAR);
    localparam int unsigned TW       = $clog2(TIMEOUT_CYC + 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_REQ      = 3'd1;
    localparam logic [2:0] S_WAIT_RDY = 3'd2;
    localparam logic [2:0] S_RUN      = 3'd3;
    localparam logic [2:0] S_DONE     = 3'd4;

    logic [2:0]           state, state_nxt;
    logic [DIM_W-1:0]     out_c;
    logic [DIM_W-1:0]     g, g_nxt;
    logic [TW-1:0]        tcnt, tcnt_nxt;
    logic [NW-1:0]        n_grp_in_c, n_grp_c, rem_c;
    logic                 start_acc_c, timeout_c, last_grp_c;
    logic [PW_OC_PAR-1:0] mask_c;

    // Group counts are one bit wider so a full-scale channel count cannot wrap
    assign n_grp_in_c = (NW'(layer_out_c) + NW'(PW_OC_PAR - 1)) >> LOG2_PAR;
    assign n_grp_c    = (NW'(out_c) + NW'(PW_OC_PAR - 1)) >> LOG2_PAR;
    assign last_grp_c = (NW'(g) == (n_grp_c - NW'(1)));
    assign rem_c      = NW'(out_c) - (NW'(g) << LOG2_PAR);

    // Lane i is live while channel g*PW_OC_PAR+i is still below out_c
    always_comb begin
        mask_c = '0;
        for (int i = 0; i < int'(PW_OC_PAR); i++) begin
            mask_c[i] = (NW'(i) < rem_c);
        end
    end

    always_comb begin
        state_nxt   = state;
        g_nxt       = g;
        tcnt_nxt    = tcnt;
        start_acc_c = 1'b0;
        timeout_c   = 1'b0;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (layer_start) begin
                        start_acc_c = 1'b1;
                        g_nxt       = '0;
                        state_nxt   = (n_grp_in_c == '0) ? S_DONE : S_REQ;
                    end
                end
                S_REQ: begin
                    tcnt_nxt  = '0;
                    state_nxt = S_WAIT_RDY;
                end
                S_WAIT_RDY: begin
                    if (pw_group_ready) begin
                        state_nxt = S_RUN;
                    end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                        timeout_c = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        tcnt_nxt = tcnt + TW'(1);
                    end
                end
                S_RUN: begin
                    if (grp_done) begin
                        if (last_grp_c) begin
                            state_nxt = S_DONE;
                        end else begin
                            g_nxt     = g + DIM_W'(1);
                            state_nxt = S_REQ;
                        end
                    end
                end
                S_DONE:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Datapath and outputs, registered from the next-state decode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_c         <= '0;
            g             <= '0;
            tcnt          <= '0;
            timeout_err   <= 1'b0;
            layer_busy    <= 1'b0;
            layer_done    <= 1'b0;
            layer_err     <= 1'b0;
            pw_group_req  <= 1'b0;
            pw_group_idx  <= '0;
            grp_valid     <= 1'b0;
            grp_idx       <= '0;
            grp_lane_mask <= '0;
        end else begin
            g    <= g_nxt;
            tcnt <= tcnt_nxt;
            if (start_acc_c) out_c <= layer_out_c;
            if (start_acc_c)    timeout_err <= 1'b0;
            else if (timeout_c) timeout_err <= 1'b1;
            layer_busy   <= (state_nxt != S_IDLE);
            layer_done   <= (state_nxt == S_DONE);
            layer_err    <= timeout_c;
            pw_group_req <= (state_nxt == S_REQ);
            grp_valid    <= (state_nxt == S_RUN);
            if (state_nxt == S_REQ) pw_group_idx <= g_nxt;
            if (state == S_WAIT_RDY && state_nxt == S_RUN) begin
                grp_idx       <= g;
                grp_lane_mask <= mask_c;
            end
        end
    end

endmodule

// File: tb/tb_mobilenet_v1_pw_group_sched.sv
// Randomized bench for the PW group scheduler against a transaction-level expectation model.
module tb_mobilenet_v1_pw_group_sched;

    localparam int unsigned DIM_W = 16;
    localparam int unsigned PAR   = 32;
    localparam int unsigned TO    = 16;

    logic             clk;
    logic             rst_n;
    logic             layer_start;
    logic [DIM_W-1:0] layer_out_c;
    logic             abort;
    logic             layer_busy, layer_done, layer_err, timeout_err;
    logic             pw_group_req;
    logic [DIM_W-1:0] pw_group_idx;
    logic             pw_group_ready;
    logic             grp_valid;
    logic [DIM_W-1:0] grp_idx;
    logic [PAR-1:0]   grp_lane_mask;
    logic             grp_done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    mobilenet_v1_pw_group_sched #(
        .DIM_W      (DIM_W),
        .PW_OC_PAR  (PAR),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .layer_start   (layer_start),
        .layer_out_c   (layer_out_c),
        .abort         (abort),
        .layer_busy    (layer_busy),
        .layer_done    (layer_done),
        .layer_err     (layer_err),
        .timeout_err   (timeout_err),
        .pw_group_req  (pw_group_req),
        .pw_group_idx  (pw_group_idx),
        .pw_group_ready(pw_group_ready),
        .grp_valid     (grp_valid),
        .grp_idx       (grp_idx),
        .grp_lane_mask (grp_lane_mask),
        .grp_done      (grp_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic quiet(input string tag);
        check({tag, "_no_done"}, 64'(layer_done), 64'd0);
        check({tag, "_no_err"},  64'(layer_err),  64'd0);
    endtask

    // Expected lane mask straight from the channel arithmetic
    function automatic logic [PAR-1:0] exp_mask(input int oc, input int g);
        longint rem;
        rem = longint'(oc) - longint'(g) * longint'(PAR);
        if (rem >= longint'(PAR)) return '1;
        return PAR'((64'd1 << rem) - 64'd1);
    endfunction

    // One layer; each bench step samples at the falling edge, then drives that cycle's inputs
    task automatic run_layer(input int oc, input int fix_dr, input int fix_dd,
                             input int abort_grp, input bit noisy);
        int n, dr, dd;
        bit stale;
        n = (oc + int'(PAR) - 1) / int'(PAR);
        layer_start = 1'b1;
        layer_out_c = DIM_W'(oc);
        abort       = 1'b0;
        @(negedge clk);
        layer_start = 1'b0;
        if (n == 0) begin
            check("zero_done", 64'(layer_done), 64'd1);
            check("zero_busy", 64'(layer_busy), 64'd1);
            check("zero_req",  64'(pw_group_req), 64'd0);
            @(negedge clk);
            check("zero_done_end", 64'(layer_done), 64'd0);
            check("zero_idle",     64'(layer_busy), 64'd0);
            return;
        end
        check("to_clr", 64'(timeout_err), 64'd0);
        for (int g = 0; g < n; g++) begin
            check("req",       64'(pw_group_req), 64'd1);
            check("req_idx",   64'(pw_group_idx), 64'(g));
            check("req_busy",  64'(layer_busy),   64'd1);
            check("req_valid", 64'(grp_valid),    64'd0);
            pw_group_ready = 1'b0;
            grp_done = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            dr = (fix_dr > 0) ? fix_dr : int'($urandom_range(1, 8));
            dd = (fix_dd > 0) ? fix_dd : int'($urandom_range(1, 6));
            for (int k = 1; k <= dr; k++) begin
                @(negedge clk);
                check("wait_req",   64'(pw_group_req), 64'd0);
                check("wait_valid", 64'(grp_valid),    64'd0);
                check("wait_idx",   64'(pw_group_idx), 64'(g));
                quiet("wait");
                if (k == dr) pw_group_ready = 1'b1;
                if (noisy) begin
                    grp_done    = 1'($urandom_range(0, 1));
                    layer_start = 1'($urandom_range(0, 1));
                    layer_out_c = DIM_W'($urandom);
                end
            end
            @(negedge clk);
            check("run_valid", 64'(grp_valid),     64'd1);
            check("run_idx",   64'(grp_idx),       64'(g));
            check("run_mask",  64'(grp_lane_mask), 64'(exp_mask(oc, g)));
            check("run_req",   64'(pw_group_req),  64'd0);
            stale = noisy && ($urandom_range(0, 1) == 1);
            if (!stale) pw_group_ready = 1'b0;
            grp_done = 1'b0;
            for (int j = 1; j < dd; j++) begin
                @(negedge clk);
                check("run_hold",     64'(grp_valid), 64'd1);
                check("run_idx_hold", 64'(grp_idx),   64'(g));
                quiet("run");
                if (noisy) layer_start = 1'($urandom_range(0, 1));
            end
            grp_done    = 1'b1;
            layer_start = 1'b0;
            if (g == abort_grp) abort = 1'b1;
            @(negedge clk);
            grp_done = 1'b0;
            if (g == abort_grp) begin
                abort = 1'b0;
                pw_group_ready = 1'b0;
                check("abort_busy",  64'(layer_busy),   64'd0);
                check("abort_valid", 64'(grp_valid),    64'd0);
                check("abort_req",   64'(pw_group_req), 64'd0);
                quiet("abort");
                repeat (3) begin
                    @(negedge clk);
                    quiet("abort_after");
                    check("abort_after_busy", 64'(layer_busy), 64'd0);
                end
                return;
            end
            if (g == n - 1) begin
                check("done",       64'(layer_done),   64'd1);
                check("done_busy",  64'(layer_busy),   64'd1);
                check("done_valid", 64'(grp_valid),    64'd0);
                check("done_req",   64'(pw_group_req), 64'd0);
            end
        end
        pw_group_ready = 1'b0;
        @(negedge clk);
        check("done_end", 64'(layer_done), 64'd0);
        check("end_idle", 64'(layer_busy), 64'd0);
    endtask

    // Ready never arrives: expect the timeout after TO waiting cycles
    task automatic run_timeout(input int oc);
        layer_start = 1'b1;
        layer_out_c = DIM_W'(oc);
        @(negedge clk);
        layer_start    = 1'b0;
        pw_group_ready = 1'b0;
        check("to_req", 64'(pw_group_req), 64'd1);
        for (int k = 1; k <= int'(TO); k++) begin
            @(negedge clk);
            check("to_wait_busy", 64'(layer_busy), 64'd1);
            quiet("to_wait");
            grp_done = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        grp_done = 1'b0;
        check("to_layer_err", 64'(layer_err),   64'd1);
        check("to_sticky",    64'(timeout_err), 64'd1);
        check("to_idle",      64'(layer_busy),  64'd0);
        check("to_no_done",   64'(layer_done),  64'd0);
        repeat (2) begin
            @(negedge clk);
            check("to_err_pulse", 64'(layer_err),   64'd0);
            check("to_hold",      64'(timeout_err), 64'd1);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        layer_start    = 1'b0;
        layer_out_c    = '0;
        abort          = 1'b0;
        pw_group_ready = 1'b0;
        grp_done       = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy",  64'(layer_busy),    64'd0);
        check("rst_done",  64'(layer_done),    64'd0);
        check("rst_err",   64'(layer_err),     64'd0);
        check("rst_to",    64'(timeout_err),   64'd0);
        check("rst_req",   64'(pw_group_req),  64'd0);
        check("rst_valid", 64'(grp_valid),     64'd0);
        check("rst_mask",  64'(grp_lane_mask), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_layer(64, 3, 6, -1, 1'b0);
        run_layer(40, -1, -1, -1, 1'b0);
        run_layer(0, -1, -1, -1, 1'b0);
        run_timeout(50);
        run_layer(33, -1, -1, -1, 1'b0);
        run_layer(96, -1, -1, 0, 1'b0);
        run_layer(96, -1, -1, -1, 1'b0);

        // Abort while waiting for ready, with ready arriving the same cycle
        layer_start = 1'b1;
        layer_out_c = DIM_W'(80);
        @(negedge clk);
        layer_start = 1'b0;
        @(negedge clk);
        abort          = 1'b1;
        pw_group_ready = 1'b1;
        @(negedge clk);
        abort          = 1'b0;
        pw_group_ready = 1'b0;
        check("abort_wait_busy",  64'(layer_busy), 64'd0);
        check("abort_wait_valid", 64'(grp_valid),  64'd0);
        @(negedge clk);
        check("abort_wait_after", 64'(grp_valid), 64'd0);
        quiet("abort_wait");

        // Abort and start together in IDLE drops the start
        layer_start = 1'b1;
        abort       = 1'b1;
        @(negedge clk);
        layer_start = 1'b0;
        abort       = 1'b0;
        check("abort_start_busy", 64'(layer_busy),   64'd0);
        check("abort_start_req",  64'(pw_group_req), 64'd0);
        @(negedge clk);
        check("abort_start_idle", 64'(layer_busy), 64'd0);

        // Reset while waiting for ready
        layer_start = 1'b1;
        layer_out_c = DIM_W'(100);
        @(negedge clk);
        layer_start = 1'b0;
        @(negedge clk);
        rst_n          = 1'b0;
        pw_group_ready = 1'b1;
        @(negedge clk);
        check("rstw_busy",  64'(layer_busy),   64'd0);
        check("rstw_req",   64'(pw_group_req), 64'd0);
        check("rstw_idx",   64'(pw_group_idx), 64'd0);
        check("rstw_valid", 64'(grp_valid),    64'd0);
        check("rstw_to",    64'(timeout_err),  64'd0);
        rst_n          = 1'b1;
        pw_group_ready = 1'b0;
        @(negedge clk);
        check("rstw_idle", 64'(layer_busy), 64'd0);

        repeat (12) begin
            int oc, ab;
            oc = int'($urandom_range(0, 300));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : -1;
            run_layer(oc, -1, -1, ab, 1'b1);
        end
        run_layer(65535, 1, 1, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
